// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: calculator sequencer between the keypad front end and the
// display driver. Builds two signed decimal operands from strobed digits,
// latches an add/sub operator, runs the external ALU through a start/finish
// handshake, presents the result with signed-overflow detection and supports
// chained operations (result becomes operand 1).
//
// Optional feature: define ALU_TIMEOUT_EN to add an ALU watchdog. WAIT then
// gives up after TIMEOUT_CYC cycles and parks in ERROR until clear.
module calc_seq_ctrl #(
  parameter int DATA_W      = 16,
  parameter int MAX_DIGITS  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              key_valid,
  input  logic [3:0]        key_digit,
  input  logic              op_valid,
  input  logic              op_sub,
  input  logic              eq_valid,
  input  logic              clr_valid,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic              alu_sub,
  output logic              alu_start,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_finish,
  output logic [DATA_W-1:0] display,
  output logic              complete,
  output logic              busy,
  output logic              ovf,
  output logic              err
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

  // Largest MAX_DIGITS-digit decimal must fit as a positive signed operand.
  if (10 ** MAX_DIGITS - 1 > 2 ** (DATA_W - 1) - 1) begin : g_bad_digits
    $error("calc_seq_ctrl: MAX_DIGITS too large for DATA_W");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("calc_seq_ctrl: TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [2:0] {
    S_ENTER1,
    S_ENTER2,
    S_ISSUE,
    S_WAIT,
    S_SHOW
`ifdef ALU_TIMEOUT_EN
    , S_ERROR
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   op1_q, op1_d;
  logic [DATA_W-1:0]   op2_q, op2_d;
  logic [CNT_W-1:0]    cnt1_q, cnt1_d;
  logic [CNT_W-1:0]    cnt2_q, cnt2_d;
  logic                opr_q, opr_d;      // operator for the operation being built
  logic                pend_q, pend_d;    // operator typed to chain the next operation
  logic                chain_q, chain_d;
  logic                fresh_q, fresh_d;
  logic [DATA_W-1:0]   in1_q, in1_d;
  logic [DATA_W-1:0]   in2_q, in2_d;
  logic                sub_q, sub_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [DATA_W-1:0]   display_q, display_d;
  logic                ovf_q, ovf_d;
`ifdef ALU_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                err_q, err_d;
`endif

  // Strobe priority: clear > equals > operator > digit.
  logic clr_s, eq_s, op_s, key_s, digit_ok;
  assign clr_s    = clr_valid;
  assign eq_s     = !clr_valid && eq_valid;
  assign op_s     = !clr_valid && !eq_valid && op_valid;
  assign key_s    = !clr_valid && !eq_valid && !op_valid && key_valid;
  assign digit_ok = (key_digit <= 4'd9);

  // Signed overflow of the ALU result against the operands it was given.
  logic in1_neg, in2_neg, res_neg, ovf_calc;
  assign in1_neg  = in1_q[DATA_W-1];
  assign in2_neg  = in2_q[DATA_W-1];
  assign res_neg  = alu_out[DATA_W-1];
  assign ovf_calc = sub_q ? ((in1_neg != in2_neg) && (res_neg != in1_neg))
                          : ((in1_neg == in2_neg) && (res_neg != in1_neg));

  function automatic logic [DATA_W-1:0] append_digit(input logic [DATA_W-1:0] v,
                                                     input logic [3:0]        d);
    return (v * DATA_W'(10)) + {{(DATA_W-4){1'b0}}, d};
  endfunction

  logic [DATA_W-1:0] op1_base;
  logic [CNT_W-1:0]  cnt1_base;

  // Next-state and datapath updates for the sequencer.
  always_comb begin
    // NOTE: every _d takes its hold value first, so no branch can leave one unassigned and infer a latch.
    state_d   = state_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    cnt1_d    = cnt1_q;
    cnt2_d    = cnt2_q;
    opr_d     = opr_q;
    pend_d    = pend_q;
    chain_d   = chain_q;
    fresh_d   = fresh_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    sub_d     = sub_q;
    result_d  = result_q;
    display_d = display_q;
    ovf_d     = ovf_q;
    op1_base  = op1_q;
    cnt1_base = cnt1_q;
`ifdef ALU_TIMEOUT_EN
    tmo_d     = tmo_q;
    err_d     = err_q;
`endif

    unique case (state_q)
      S_ENTER1: begin
        if (clr_s) begin
          state_d = S_ENTER1;
        end else if (op_s) begin
          opr_d   = op_sub;
          op2_d   = '0;
          cnt2_d  = '0;
          fresh_d = 1'b0;
          state_d = S_ENTER2;
        end else if (key_s) begin
          // After a result, a digit starts a brand-new operand 1.
          op1_base  = fresh_q ? '0 : op1_q;
          cnt1_base = fresh_q ? '0 : cnt1_q;
          op1_d     = op1_base;
          cnt1_d    = cnt1_base;
          fresh_d   = 1'b0;
          if (digit_ok && (cnt1_base < MAX_CNT)) begin
            op1_d  = append_digit(op1_base, key_digit);
            cnt1_d = cnt1_base + CNT_W'(1);
          end
          display_d = op1_d;
        end
      end

      S_ENTER2: begin
        if (clr_s) begin
          state_d = S_ENTER1;
        end else if ((eq_s || op_s) && (cnt2_q != '0)) begin
          in1_d   = op1_q;
          in2_d   = op2_q;
          sub_d   = opr_q;
          chain_d = op_s;
          if (op_s) pend_d = op_sub;
          state_d = S_ISSUE;
        end else if (op_s) begin
          opr_d = op_sub;
        end else if (key_s) begin
          if (digit_ok && (cnt2_q < MAX_CNT)) begin
            op2_d     = append_digit(op2_q, key_digit);
            cnt2_d    = cnt2_q + CNT_W'(1);
            display_d = append_digit(op2_q, key_digit);
          end
        end
      end

      S_ISSUE: begin
        ovf_d   = 1'b0;
        state_d = S_WAIT;
`ifdef ALU_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end

      S_WAIT: begin
        if (alu_finish) begin
          result_d  = alu_out;
          display_d = alu_out;
          ovf_d     = ovf_calc;
          state_d   = S_SHOW;
        end
`ifdef ALU_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          err_d     = 1'b1;
          display_d = '0;
          state_d   = S_ERROR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end

      S_SHOW: begin
        display_d = result_q;
        op1_d     = result_q;
        cnt1_d    = '0;
        if (chain_q) begin
          opr_d   = pend_q;
          op2_d   = '0;
          cnt2_d  = '0;
          state_d = S_ENTER2;
        end else begin
          fresh_d = 1'b1;
          state_d = S_ENTER1;
        end
      end

`ifdef ALU_TIMEOUT_EN
      S_ERROR: begin
        if (clr_s) state_d = S_ENTER1;
      end
`endif

      default: state_d = S_ENTER1;
    endcase

    // Clear acts only where strobes are honoured; it overrides the updates above.
    if (clr_s && (state_q == S_ENTER1 || state_q == S_ENTER2
`ifdef ALU_TIMEOUT_EN
                  || state_q == S_ERROR
`endif
                 )) begin
      op1_d     = '0;
      op2_d     = '0;
      cnt1_d    = '0;
      cnt2_d    = '0;
      display_d = '0;
      ovf_d     = 1'b0;
      fresh_d   = 1'b0;
      state_d   = S_ENTER1;
`ifdef ALU_TIMEOUT_EN
      err_d     = 1'b0;
`endif
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      // NOTE: datapath registers are reset too, because every output must read 0 straight out of reset.
      state_q   <= S_ENTER1;
      op1_q     <= '0;
      op2_q     <= '0;
      cnt1_q    <= '0;
      cnt2_q    <= '0;
      opr_q     <= 1'b0;
      pend_q    <= 1'b0;
      chain_q   <= 1'b0;
      fresh_q   <= 1'b0;
      in1_q     <= '0;
      in2_q     <= '0;
      sub_q     <= 1'b0;
      result_q  <= '0;
      display_q <= '0;
      ovf_q     <= 1'b0;
`ifdef ALU_TIMEOUT_EN
      tmo_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      cnt1_q    <= cnt1_d;
      cnt2_q    <= cnt2_d;
      opr_q     <= opr_d;
      pend_q    <= pend_d;
      chain_q   <= chain_d;
      fresh_q   <= fresh_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      sub_q     <= sub_d;
      result_q  <= result_d;
      display_q <= display_d;
      ovf_q     <= ovf_d;
`ifdef ALU_TIMEOUT_EN
      tmo_q     <= tmo_d;
      err_q     <= err_d;
`endif
    end
  end

  assign alu_in1   = in1_q;
  assign alu_in2   = in2_q;
  assign alu_sub   = sub_q;
  assign alu_start = (state_q == S_ISSUE);
  assign complete  = (state_q == S_SHOW);
  assign busy      = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign display   = display_q;
  assign ovf       = ovf_q;
`ifdef ALU_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Self-checking bench for calc_seq_ctrl: a behavioural ALU answers start
// pulses, and a scoreboard queue holds the operation expected for each start.
module tb_calc_seq_ctrl;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          nRST = 1'b0;
  logic          key_valid = 1'b0;
  logic [3:0]    key_digit = 4'd0;
  logic          op_valid = 1'b0;
  logic          op_sub = 1'b0;
  logic          eq_valid = 1'b0;
  logic          clr_valid = 1'b0;
  logic [DW-1:0] alu_in1, alu_in2;
  logic          alu_sub, alu_start;
  logic [DW-1:0] alu_out = '0;
  logic          alu_finish = 1'b0;
  logic [DW-1:0] display;
  logic          complete, busy, ovf, err;

  calc_seq_ctrl #(.DATA_W(DW), .MAX_DIGITS(4), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .nRST(nRST),
    .key_valid(key_valid), .key_digit(key_digit),
    .op_valid(op_valid), .op_sub(op_sub),
    .eq_valid(eq_valid), .clr_valid(clr_valid),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sub(alu_sub), .alu_start(alu_start),
    .alu_out(alu_out), .alu_finish(alu_finish),
    .display(display), .complete(complete), .busy(busy), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [DW-1:0] in1;
    logic [DW-1:0] in2;
    logic          sub;
    logic [DW-1:0] res;
    logic          ovf;
  } exp_t;

  exp_t sb_q[$];

  // Expected operation: result and overflow come from full-range integer math.
  task automatic expect_op(input int a, input int b, input logic s);
    exp_t e;
    int   full;
    logic [DW-1:0] a16, b16;
    a16   = DW'(a);
    b16   = DW'(b);
    full  = s ? ($signed(a16) - $signed(b16)) : ($signed(a16) + $signed(b16));
    e.in1 = a16;
    e.in2 = b16;
    e.sub = s;
    e.res = DW'(full);
    e.ovf = (full > 32767) || (full < -32768);
    sb_q.push_back(e);
  endtask

  // Behavioural ALU: answers a start pulse after alu_delay cycles.
  logic alu_en    = 1'b1;
  int   alu_delay = 1;
  int   fin_cyc   = 0;
  initial forever begin
    @(negedge clk);
    if (alu_start && alu_en) begin : respond
      logic [DW-1:0] r;
      r = alu_sub ? (alu_in1 - alu_in2) : (alu_in1 + alu_in2);
      repeat (alu_delay) @(posedge clk);
      #1;
      alu_out    = r;
      alu_finish = 1'b1;
      fin_cyc    = cyc;
      @(posedge clk);
      #1 alu_finish = 1'b0;
    end
  end

  // Monitor: start pulses and completions are matched against the scoreboard.
  int   starts     = 0;
  int   wait_entry = 0;
  exp_t cur;
  always @(negedge clk) begin
    if (alu_start) begin
      starts++;
      wait_entry = cyc + 1;
      if (sb_q.size() > 0) begin
        check("start_in1", alu_in1, sb_q[0].in1);
        check("start_in2", alu_in2, sb_q[0].in2);
        check("start_sub", alu_sub, sb_q[0].sub);
      end else begin
        check("start_unexpected_sb_size", sb_q.size(), 1);
      end
    end
    if (complete) begin
      if (sb_q.size() > 0) begin
        cur = sb_q.pop_front();
        check("res_display", display, cur.res);
        check("res_ovf", ovf, cur.ovf);
        check("res_held_in1", alu_in1, cur.in1);
        check("res_held_in2", alu_in2, cur.in2);
        check("res_start_pulses", starts, 1);
        check("res_latency", cyc, fin_cyc + 1);
        starts = 0;
      end else begin
        check("complete_unexpected_sb_size", sb_q.size(), 1);
      end
    end
  end

  task automatic strobe(input logic k, input logic e, input logic o, input logic c,
                        input logic [3:0] d, input logic s);
    @(posedge clk);
    #1;
    key_valid = k; eq_valid = e; op_valid = o; clr_valid = c;
    key_digit = d; op_sub = s;
    @(posedge clk);
    #1;
    key_valid = 1'b0; eq_valid = 1'b0; op_valid = 1'b0; clr_valid = 1'b0;
  endtask

  task automatic key(input logic [3:0] d); strobe(1'b1, 1'b0, 1'b0, 1'b0, d, 1'b0); endtask
  task automatic op(input logic s);        strobe(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, s);  endtask
  task automatic eq();                     strobe(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0); endtask
  task automatic clr();                    strobe(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0); endtask

  task automatic num(input int n);
    string s;
    s = $sformatf("%0d", n);
    for (int i = 0; i < s.len(); i++) key(4'(s[i] - 8'd48));
  endtask

  // Wait (bounded) until the pending operation has completed and the DUT is idle.
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sb_q.size() != 0 || busy || complete) && n < 300);
    check(tag, sb_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_display", display, 0);
    check("rst_flags", {busy, complete, ovf, err, alu_start, alu_sub}, 0);
    check("rst_alu_in", {alu_in1, alu_in2}, 0);
    nRST = 1'b1;

    // 123 + 45, ALU answers after 3 cycles.
    alu_delay = 3;
    num(123);
    check("t1_disp_op1", display, 123);
    op(1'b0);
    num(45);
    check("t1_disp_op2", display, 45);
    expect_op(123, 45, 1'b0);
    eq();
    wait_idle("t1_done");
    check("t1_display_after", display, 168);
    check("t1_ovf", ovf, 0);

    // Fifth digit dropped, non-BCD digit ignored.
    alu_delay = 1;
    clr();
    check("clr_display", display, 0);
    num(99999);
    check("t2_max_digits", display, 9999);
    key(4'hB);
    check("t2_bad_digit", display, 9999);

    // Chain up to 30000, then + 5000 overflows to 0x88B8.
    clr();
    num(9999); op(1'b0); num(9999);
    expect_op(9999, 9999, 1'b0); op(1'b0); wait_idle("t3_c1");
    num(9999);
    expect_op(19998, 9999, 1'b0); op(1'b0); wait_idle("t3_c2");
    num(3);
    expect_op(29997, 3, 1'b0); op(1'b0); wait_idle("t3_c3");
    num(5000);
    expect_op(30000, 5000, 1'b0); eq(); wait_idle("t3_c4");
    check("t3_ovf", ovf, 1);
    check("t3_display", display, 16'h88B8);
    key(4'd1);
    check("t3_fresh_digit", display, 1);
    check("t3_ovf_sticky", ovf, 1);

    // 7 - 3, chained add of 2.
    clr();
    num(7); op(1'b1); num(3);
    expect_op(7, 3, 1'b1); op(1'b0); wait_idle("t4_c1");
    check("t4_ovf_cleared", ovf, 0);
    num(2);
    expect_op(4, 2, 1'b0); eq(); wait_idle("t4_c2");
    check("t4_display", display, 6);

    // Operator continues from the result; a digit starts over.
    op(1'b1); num(1);
    expect_op(6, 1, 1'b1); eq(); wait_idle("t5_cont");
    num(4);
    check("t5_new_calc", display, 4);
    op(1'b0);
    op(1'b1);            // re-latch with empty operand 2
    eq();                // ignored with empty operand 2
    num(3);
    expect_op(4, 3, 1'b1);
    strobe(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);  // eq beats op: no chain
    wait_idle("t5_eq_wins");
    key(4'd2); op(1'b0); num(2);
    expect_op(2, 2, 1'b0); eq(); wait_idle("t5_after_eq");
    check("t5_display", display, 4);

    // Negative result.
    clr();
    num(3); op(1'b1); num(7);
    expect_op(3, 7, 1'b1); eq(); wait_idle("t6_neg");
    check("t6_display", display, 16'hFFFC);

    // Clear beats a simultaneous digit in ENTER2.
    clr();
    num(5); op(1'b0); num(8);
    strobe(1'b1, 1'b0, 1'b0, 1'b1, 4'd9, 1'b0);
    check("t7_clr_wins", display, 0);
    num(2); op(1'b1); num(1);
    expect_op(2, 1, 1'b1); eq(); wait_idle("t7_after_clr");

    // Reset mid-WAIT, then a late finish.
    alu_en = 1'b0;
    clr();
    num(1); op(1'b0); num(1);
    expect_op(1, 1, 1'b0); eq();
    repeat (3) @(posedge clk);
    #1;
    check("t8_busy_wait", busy, 1);
    nRST = 1'b0;
    #2;
    check("t8_rst_display", display, 0);
    check("t8_rst_flags", {busy, complete, ovf, err, alu_start, alu_sub}, 0);
    check("t8_rst_alu_in", {alu_in1, alu_in2}, 0);
    sb_q.delete();
    starts = 0;
    @(posedge clk);
    #1 nRST = 1'b1;
    @(posedge clk);
    #1;
    alu_out    = 16'h1234;
    alu_finish = 1'b1;
    @(posedge clk);
    #1 alu_finish = 1'b0;
    @(negedge clk);
    check("t8_late_complete", complete, 0);
    check("t8_late_display", display, 0);
    alu_en = 1'b1;
    num(2); op(1'b0); num(3);
    expect_op(2, 3, 1'b0); eq(); wait_idle("t8_after_rst");

`ifdef ALU_TIMEOUT_EN
    // Watchdog: no finish, err after 64 WAIT cycles.
    begin : timeout_case
      int n;
      alu_en = 1'b0;
      clr();
      num(1); op(1'b0); num(1);
      expect_op(1, 1, 1'b0); eq();
      n = 0;
      while (!err && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("t9_err_delay", cyc - wait_entry, 64);
      check("t9_err", err, 1);
      check("t9_busy", busy, 0);
      check("t9_display", display, 0);
      key(4'd5);
      check("t9_key_ignored", display, 0);
      clr();
      check("t9_err_cleared", err, 0);
      sb_q.delete();
      starts = 0;
      alu_en = 1'b1;
      num(4); op(1'b0); num(4);
      expect_op(4, 4, 1'b0); eq(); wait_idle("t9_after_clr");
    end
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calc_seq_ctrl.md
Name: calc_seq_ctrl

Overview:
- Parametrised calculator sequencer for signed operands of DATA_W bits.
- Builds two decimal operands from strobed keypad digits and latches an add/sub operator.
- Drives the addition/subtraction ALU through a start/finish handshake, then presents the result with overflow detection.
- Supports chained operations (result becomes operand 1) and sits between the keypad front end and the display driver.

Parameters:
- DATA_W, 16: operand/result width, two's complement.
- MAX_DIGITS, 4: maximum decimal digits per operand. Must satisfy 10^MAX_DIGITS-1 <= 2^(DATA_W-1)-1.
- TIMEOUT_CYC, 64: ALU watchdog limit in cycles. Used only with ALU_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- key_valid  in  1  one-cycle digit strobe
- key_digit  in  4  BCD digit; values 10-15 ignored
- op_valid  in  1  one-cycle operator strobe
- op_sub  in  1  operator select with op_valid: 0 = add, 1 = sub
- eq_valid  in  1  one-cycle equals strobe
- clr_valid  in  1  one-cycle clear strobe
- alu_in1  out  DATA_W  operand 1 to ALU, held stable through WAIT
- alu_in2  out  DATA_W  operand 2 to ALU, held stable through WAIT
- alu_sub  out  1  ALU mode, held stable through WAIT
- alu_start  out  1  one-cycle start pulse
- alu_out  in  DATA_W  ALU result
- alu_finish  in  1  ALU done, sampled only in WAIT
- display  out  DATA_W  operand being entered, or result
- complete  out  1  one-cycle pulse when result is valid
- busy  out  1  high in ISSUE and WAIT
- ovf  out  1  signed overflow of last result; sticky until next ISSUE or clear
- err  out  1  watchdog error; cleared only by clear or reset

Behaviour:
- Reset (async assert, sync release): state ENTER1; all outputs and registers 0; digit counters 0; fresh flag 0.
- Input priority within one cycle: clr_valid > eq_valid > op_valid > key_valid. Only the highest-priority strobe acts.
- All strobes ignored in ISSUE and WAIT, including clear.
- Digit append: operand <= operand*10 + key_digit, only if digit count < MAX_DIGITS and key_digit <= 9. Otherwise the digit is dropped silently. display follows the active operand on the next cycle.
- ENTER1:
  - digit: if fresh=1, operand1 is first cleared to 0 and count to 0, then the digit is appended; fresh <= 0.
  - op: latch op_sub; clear operand2 and its count; go to ENTER2.
  - eq: no effect.
- ENTER2:
  - digit: append to operand2.
  - op or eq with operand2 count = 0: op re-latches the operator; eq is ignored.
  - eq with count > 0: go to ISSUE; chain <= 0.
  - op with count > 0: go to ISSUE; chain <= 1; the new operator is stored as pending.
- ISSUE, one cycle: alu_in1 <= operand1, alu_in2 <= operand2, alu_sub <= op; alu_start = 1 for exactly this cycle; go to WAIT.
- WAIT: on alu_finish, result <= alu_out and go to SHOW.
- ovf, computed in WAIT on finish:
  - add: in1 and in2 same sign and result sign differs.
  - sub: in1 and in2 signs differ and result sign differs from in1.
- SHOW, one cycle: complete = 1; display <= result; operand1 <= result.
  - chain = 0: go to ENTER1 with fresh = 1, so a new digit starts a new calculation and an operator continues from the result.
  - chain = 1: latch the pending operator, clear operand2, go to ENTER2.
- clear in ENTER1/ENTER2/ERROR: operands, counts, display, ovf and err go to 0; state ENTER1.
- Latency: ISSUE to alu_start is 0 cycles. alu_finish at cycle N gives complete at N+1.
- Reset mid-WAIT aborts the operation; a late alu_finish is ignored outside WAIT.

Optional Feature:
- Macro: ALU_TIMEOUT_EN.
- Defined: a counter clears on entry to WAIT and increments each WAIT cycle. If it reaches TIMEOUT_CYC without alu_finish, go to ERROR: err = 1, display = 0, busy = 0. ERROR exits to ENTER1 only on clear.
- Not defined: no counter and no ERROR state; WAIT holds indefinitely; err is tied to 0.

Test Plan:
- Keys 1,2,3, op add, keys 4,5, eq; ALU returns 168 after 3 cycles -> alu_start single pulse with in1=123, in2=45, sub=0; complete pulse; display=168; ovf=0.
- Keys 9,9,9,9,9 -> fifth digit dropped; display=9999.
- 30000 + 5000, ALU returns 0x88B8 -> ovf=1; display=0x88B8.
- 7 sub 3, then op add (chain), 2, eq -> first result 4 with alu_sub=1; second issue has in1=4, in2=2, sub=0; display=6.
- key_valid and clr_valid asserted together in ENTER2 -> clear wins; state ENTER1; display=0. nRST pulsed low mid-WAIT -> all outputs 0; later alu_finish ignored.
- ALU_TIMEOUT_EN defined, TIMEOUT_CYC=64, no alu_finish -> err=1 exactly 64 cycles after entering WAIT; digit strobes ignored; clear returns to ENTER1 with err=0.
